// File: rtl/mem_common_pkg.sv
// Shared memory-side types for the front-end fetch path: FE request/response,
// fetch-buffer line request/response, and fetch-buffer sizing defaults.
package mem_common;

    localparam int PADDR_W       = 32;
    localparam int FE_ID_W       = 4;
    localparam int FB_LINE_BYTES = 64;
    localparam int FB_NUM_LINES  = 4;

    typedef logic [PADDR_W-1:0]         t_paddr;
    typedef logic [31:0]                t_rv_instr;
    typedef logic [FE_ID_W-1:0]         t_fe_id;
    typedef logic [1:0]                 t_fb_tag;
    typedef logic [FB_LINE_BYTES*8-1:0] t_fb_line;

    typedef struct packed {
        logic   valid;
        t_paddr addr;
        t_fe_id id;
    } t_fe_fb_req;

    typedef struct packed {
        logic      valid;
        t_rv_instr instr;
        t_paddr    pc;
        t_fe_id    id;
    } t_fb_fe_rsp;

    typedef struct packed {
        logic    valid;
        t_paddr  addr;
        t_fb_tag tag;
    } t_fb_mem_req;

    typedef struct packed {
        logic     valid;
        t_fb_tag  tag;
        t_fb_line data;
    } t_mem_fb_rsp;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_MISS_REQ,
        FB_MISS_WAIT,
        FB_FILL_RSP
    } t_fb_state;

endpackage

// File: rtl/fetch_buf_tags.sv
// Fully-associative tag store for the fetch buffer: per-line valid + tag,
// parallel lookup, and a round-robin victim pointer that advances on install.
module fetch_buf_tags
    import mem_common::*;
#(
    parameter int NUM_LINES = FB_NUM_LINES,
    parameter int TAG_W     = PADDR_W - $clog2(FB_LINE_BYTES),
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    input  logic             install,
    input  logic [TAG_W-1:0] install_tag,
    output logic [IDX_W-1:0] victim_idx
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [NUM_LINES-1:0] hit_vec;

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
                hit_vec[i] = 1'b1;
                hit_idx    = IDX_W'(i);
            end
        end
    end

    assign hit        = |hit_vec;
    assign victim_idx = victim_q;

    // Flush wins over a same-cycle install; the pointer wraps by width.
    always_comb begin
        valid_d  = valid_q;
        victim_d = victim_q;
        if (install) begin
            valid_d[victim_q] = 1'b1;
            victim_d          = victim_q + IDX_W'(1);
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
        end
    end

    // NOTE: tag storage is not reset; valid_q alone decides whether an entry counts.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[victim_q] <= install_tag;
        end
    end

`ifdef ASSERT
    a_hit_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(hit_vec))
        else $error("fetch_buf_tags: multiple lines hit");
`endif

endmodule

// File: rtl/fetch_buf.sv
// Fetch buffer: answers single-outstanding FE instruction fetches from a small
// fully-associative line buffer, filling misses over a tagged line port.
module fetch_buf
    import mem_common::*;
#(
    parameter int NUM_LINES  = FB_NUM_LINES,
    parameter int LINE_BYTES = FB_LINE_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  t_fe_fb_req  fe_fb_req_nnn,
    output t_fb_fe_rsp  fb_fe_rsp_nnn,
    output t_fb_mem_req fb_mem_req,
    input  logic        mem_fb_req_rdy,
    input  t_mem_fb_rsp mem_fb_rsp
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int TAG_W  = PADDR_W - OFF;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int WIDX_W = OFF - 2;
    localparam int LINE_W = LINE_BYTES * 8;

    t_fb_state  state_q, state_d;
    t_paddr     addr_q, addr_d;
    t_fe_id     id_q, id_d;
    t_fb_tag    cur_tag_q, cur_tag_d;
    logic       fill_drop_q, fill_drop_d;
    t_fb_fe_rsp rsp_q, rsp_d;

    logic [LINE_W-1:0] data_q [NUM_LINES];

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             req_ok;
    logic             fill_ok;
    logic             install;
    logic             unused_addr_lsbs;

    function automatic t_rv_instr pick_word(input logic [LINE_W-1:0] line,
                                            input logic [WIDX_W-1:0] widx);
        return line[widx*32 +: 32];
    endfunction

    // Requests overlapping a pending response or a miss are protocol errors and ignored.
    assign req_ok  = fe_fb_req_nnn.valid && (state_q == FB_IDLE) && !rsp_q.valid;
    assign fill_ok = (state_q == FB_MISS_WAIT) && mem_fb_rsp.valid
                     && (mem_fb_rsp.tag == cur_tag_q);
    assign install = fill_ok && !(fill_drop_q || flush);

    assign unused_addr_lsbs = ^fe_fb_req_nnn.addr[1:0];

    fetch_buf_tags #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_tags (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_tag  (fe_fb_req_nnn.addr[PADDR_W-1:OFF]),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .install     (install),
        .install_tag (addr_q[PADDR_W-1:OFF]),
        .victim_idx  (victim_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FB_IDLE:      if (req_ok && !hit)  state_d = FB_MISS_REQ;
            FB_MISS_REQ:  if (mem_fb_req_rdy)  state_d = FB_MISS_WAIT;
            FB_MISS_WAIT: if (fill_ok)         state_d = FB_FILL_RSP;
            FB_FILL_RSP:                       state_d = FB_IDLE;
            default:                           state_d = FB_IDLE;
        endcase
    end

    always_comb begin
        fb_mem_req = '0;
        if (state_q == FB_MISS_REQ) begin
            fb_mem_req.valid = 1'b1;
            fb_mem_req.addr  = addr_q & ~t_paddr'(LINE_BYTES - 1);
            fb_mem_req.tag   = cur_tag_q;
        end
    end

    assign fb_fe_rsp_nnn = rsp_q;

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        addr_d      = addr_q;
        id_d        = id_q;
        cur_tag_d   = cur_tag_q;
        fill_drop_d = fill_drop_q;
        rsp_d       = '0;

        if (req_ok) begin
            addr_d = fe_fb_req_nnn.addr;
            id_d   = fe_fb_req_nnn.id;
            if (hit) begin
                rsp_d.valid = 1'b1;
                rsp_d.instr = pick_word(data_q[hit_idx], fe_fb_req_nnn.addr[OFF-1:2]);
                rsp_d.pc    = fe_fb_req_nnn.addr;
                rsp_d.id    = fe_fb_req_nnn.id;
            end
        end

        // The FE word is taken straight off the fill so a dropped fill still answers.
        if (fill_ok) begin
            cur_tag_d   = cur_tag_q + 2'd1;
            rsp_d.valid = 1'b1;
            rsp_d.instr = pick_word(mem_fb_rsp.data, addr_q[OFF-1:2]);
            rsp_d.pc    = addr_q;
            rsp_d.id    = id_q;
        end

        if (flush && ((state_q == FB_MISS_REQ) || (state_q == FB_MISS_WAIT))) begin
            fill_drop_d = 1'b1;
        end
        if (state_q == FB_FILL_RSP) begin
            fill_drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            id_q        <= '0;
            cur_tag_q   <= '0;
            fill_drop_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            id_q        <= id_d;
            cur_tag_q   <= cur_tag_d;
            fill_drop_q <= fill_drop_d;
            rsp_q       <= rsp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            data_q[victim_idx] <= mem_fb_rsp.data;
        end
    end

`ifdef ASSERT
    a_single_outstanding: assert property (@(posedge clk) disable iff (reset)
        fe_fb_req_nnn.valid |-> (state_q == FB_IDLE) && !rsp_q.valid)
        else $error("fetch_buf: request while busy");

    a_aligned: assert property (@(posedge clk) disable iff (reset)
        fe_fb_req_nnn.valid |-> (fe_fb_req_nnn.addr[1:0] == 2'b00))
        else $error("fetch_buf: misaligned fetch address");

    a_mem_req_stable: assert property (@(posedge clk) disable iff (reset)
        (fb_mem_req.valid && !mem_fb_req_rdy) |=>
            fb_mem_req.valid && $stable(fb_mem_req.addr) && $stable(fb_mem_req.tag))
        else $error("fetch_buf: mem request changed before acceptance");
`endif

endmodule

// File: tb/tb_fetch_buf.sv
// Directed plus randomized bench for fetch_buf against a line-level cache model.
module tb_fetch_buf;
    import mem_common::*;

    localparam int NL = FB_NUM_LINES;
    localparam int LB = FB_LINE_BYTES;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        mem_fb_req_rdy;
    t_fe_fb_req  req;
    t_fb_fe_rsp  rsp;
    t_fb_mem_req mreq;
    t_mem_fb_rsp mrsp;

    always #5 clk = ~clk;

    fetch_buf dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .fe_fb_req_nnn  (req),
        .fb_fe_rsp_nnn  (rsp),
        .fb_mem_req     (mreq),
        .mem_fb_req_rdy (mem_fb_req_rdy),
        .mem_fb_rsp     (mrsp)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: which memory lines are buffered, victim order, next tag.
    bit          m_v    [NL];
    logic [31:0] m_line [NL];
    int          m_victim;
    logic [1:0]  m_tag;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LB - 1);
    endfunction

    // Memory image: line 0x1000 holds 0x100+k; other lines get distinct high bits.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] l;
        logic [31:0] k;
        l = line_of(a);
        k = (a % LB) / 4;
        return (l >> 4) + k + (((l >> 6) - 32'h40) << 16);
    endfunction

    function automatic t_fb_line line_data(input logic [31:0] a);
        t_fb_line d;
        for (int k = 0; k < LB / 4; k++) d[k*32 +: 32] = mem_word(line_of(a) + 32'(4 * k));
        return d;
    endfunction

    function automatic int m_find(input logic [31:0] a);
        for (int i = 0; i < NL; i++) if (m_v[i] && m_line[i] == line_of(a)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
        m_victim = 0;
        m_tag    = 2'd0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [3:0] id, input int rdy_delay,
                            input bit stale, input bit flush_wait, input bit flush_req);
        bit exp_hit;
        exp_hit = (m_find(a) >= 0);
        req     = '{valid: 1'b1, addr: a, id: id};
        flush   = flush_req;
        step();
        req.valid = 1'b0;
        flush     = 1'b0;
        if (flush_req) model_flush();
        if (exp_hit) begin
            check("hit_rsp_valid", rsp.valid, 1);
            check("hit_rsp_instr", rsp.instr, mem_word(a));
            check("hit_rsp_pc",    rsp.pc, a);
            check("hit_rsp_id",    rsp.id, id);
            check("hit_no_memreq", mreq.valid, 0);
        end else begin
            check("miss_no_rsp",    rsp.valid, 0);
            check("memreq_valid",   mreq.valid, 1);
            check("memreq_addr",    mreq.addr, line_of(a));
            check("memreq_tag",     mreq.tag, m_tag);
            for (int d = 0; d < rdy_delay; d++) begin
                mem_fb_req_rdy = 1'b0;
                step();
                check("bp_memreq_valid", mreq.valid, 1);
                check("bp_memreq_addr",  mreq.addr, line_of(a));
                check("bp_memreq_tag",   mreq.tag, m_tag);
            end
            mem_fb_req_rdy = 1'b1;
            step();
            mem_fb_req_rdy = 1'b0;
            check("memreq_released", mreq.valid, 0);
            if (flush_wait) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                model_flush();
            end
            if (stale) begin
                mrsp = '{valid: 1'b1, tag: m_tag + 2'd3, data: ~line_data(a)};
                step();
                mrsp.valid = 1'b0;
                check("stale_dropped", rsp.valid, 0);
            end
            mrsp = '{valid: 1'b1, tag: m_tag, data: line_data(a)};
            step();
            mrsp.valid = 1'b0;
            check("fill_rsp_valid", rsp.valid, 1);
            check("fill_rsp_instr", rsp.instr, mem_word(a));
            check("fill_rsp_pc",    rsp.pc, a);
            check("fill_rsp_id",    rsp.id, id);
            if (!flush_wait) begin
                m_line[m_victim] = line_of(a);
                m_v[m_victim]    = 1'b1;
                m_victim         = (m_victim + 1) % NL;
            end
            m_tag = m_tag + 2'd1;
        end
        step();
        check("rsp_one_pulse", rsp.valid, 0);
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        mem_fb_req_rdy = 1'b0;
        req            = '0;
        mrsp           = '0;
        model_reset();
        repeat (2) step();
        check("reset_rsp_valid",    rsp.valid, 0);
        check("reset_memreq_valid", mreq.valid, 0);
        reset = 1'b0;
        step();

        // Cold miss at minimum latency, then a hit in the same line.
        do_fetch(32'h1000, 4'd0, 0, 0, 0, 0);
        check("cold_line_buffered", m_find(32'h1000) >= 0, 1);
        do_fetch(32'h1004, 4'd1, 0, 0, 0, 0);

        // Replacement: a fifth line evicts the first; re-fetch it, then entry 3 still hits.
        do_fetch(32'h1040, 4'd2, 1, 0, 0, 0);
        do_fetch(32'h1080, 4'd3, 0, 0, 0, 0);
        do_fetch(32'h10c0, 4'd4, 2, 0, 0, 0);
        do_fetch(32'h1100, 4'd5, 0, 0, 0, 0);
        check("evicted_line0", m_find(32'h1000) < 0, 1);
        do_fetch(32'h1008, 4'd6, 0, 0, 0, 0);
        do_fetch(32'h10fc, 4'd7, 0, 0, 0, 0);
        do_fetch(32'h1044, 4'd8, 0, 0, 0, 0);

        // Flush during the miss: data returned, not installed.
        do_fetch(32'h3000, 4'd9, 0, 0, 1, 0);
        do_fetch(32'h3010, 4'd10, 0, 0, 0, 0);

        // Flush coincident with a hit: answered from pre-flush contents, then gone.
        do_fetch(32'h3014, 4'd11, 0, 0, 0, 1);
        do_fetch(32'h3018, 4'd12, 0, 0, 0, 0);

        // Backpressure for five cycles and a stale-tag response.
        do_fetch(32'h3040, 4'd13, 5, 1, 0, 0);

        // Reset while waiting for a fill.
        req = '{valid: 1'b1, addr: 32'h3080, id: 4'd14};
        step();
        req.valid      = 1'b0;
        mem_fb_req_rdy = 1'b1;
        step();
        mem_fb_req_rdy = 1'b0;
        reset          = 1'b1;
        step();
        reset = 1'b0;
        check("midmiss_rst_rsp_zero",    rsp == '0, 1);
        check("midmiss_rst_memreq_zero", mreq == '0, 1);
        model_reset();
        do_fetch(32'h2000, 4'd15, 0, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            do_fetch(32'h4000 + 32'($urandom_range(0, 7) * LB) + 32'($urandom_range(0, 15) * 4),
                     4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
